comms_ctrl_param: RTL and testbench

COMMS_CTRL_PARAM -- requirements
Module: comms_ctrl_param

---
 rtl/comms_ctrl_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_comms_ctrl_param.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comms_ctrl_param.sv
// Packet controller that decodes incoming words. It performs regmap writes and
// reads for config packets addressed to this chip. It forwards all other
// traffic to the transmitter or the FIFO and injects local events into the FIFO.
// Every output is a register loaded from the next-state logic, so each strobe
// lines up with the state that owns it.
module comms_ctrl_param #(
  parameter int          WIDTH        = 64,
  parameter int          ADDR_W       = 8,
  parameter int          DATA_W       = 8,
  parameter int          READ_LAT     = 5,
  parameter int          TIMEOUT      = 15,
  parameter logic [7:0]  GLOBAL_ID    = 8'd255,
  parameter logic [31:0] MAGIC_NUMBER = 32'h89504E47
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        chip_id,
  input  logic [WIDTH-1:0]  rx_data,
  input  logic              rx_valid,
  output logic              rx_ack,
  input  logic [WIDTH-1:0]  pre_event,
  input  logic              event_valid,
  output logic              event_ack,
  input  logic              fifo_full,
  output logic [WIDTH-1:0]  fifo_wr_data,
  output logic              fifo_wr_en,
  input  logic              tx_busy,
  output logic [WIDTH-1:0]  tx_data,
  output logic              tx_load,
  output logic [ADDR_W-1:0] regmap_address,
  output logic [DATA_W-1:0] regmap_write_data,
  input  logic [DATA_W-1:0] regmap_read_data,
  output logic              write_regmap,
  output logic              read_regmap,
  output logic [15:0]       total_packets,
  output logic [15:0]       bad_packets,
  output logic [15:0]       dropped_packets,
  output logic              comms_busy
);

  localparam int ADDR_LO  = 10;
  localparam int DATA_LO  = ADDR_LO + ADDR_W;
  localparam int MAGIC_LO = DATA_LO + DATA_W;
  localparam logic [7:0] LAT_LAST = 8'(READ_LAT - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    READY,
    CFG_WRITE,
    CFG_READ,
    CFG_READ_LATCH,
    FWD,
    LOCAL_EVENT,
    WRITE_FIFO,
    BAD_PACKET,
    WAIT_STATE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_pkt;
  logic [7:0]        r_cnt;

  logic [WIDTH-1:0]  w_pkt;
  logic [7:0]        w_cnt;
  logic              w_rx_ack;
  logic              w_event_ack;
  logic              w_fifo_wr_en;
  logic [WIDTH-1:0]  w_fifo_wr_data;
  logic              w_tx_load;
  logic [WIDTH-1:0]  w_tx_data;
  logic              w_write;
  logic              w_read;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_inc_total;
  logic              w_inc_bad;
  logic              w_inc_drop;
  logic [WIDTH-1:0]  w_reply;

  logic [1:0]        w_rx_op;
  logic [7:0]        w_rx_id;
  logic [ADDR_W-1:0] w_rx_addr;
  logic [DATA_W-1:0] w_rx_field;
  logic [31:0]       w_rx_magic;
  logic              w_rx_bad;
  logic              w_id_match;
  logic              w_pkt_global;
  logic              w_pkt_cfg;

  assign w_rx_op      = rx_data[1:0];
  assign w_rx_id      = rx_data[9:2];
  assign w_rx_addr    = rx_data[ADDR_LO +: ADDR_W];
  assign w_rx_field   = rx_data[DATA_LO +: DATA_W];
  assign w_rx_magic   = rx_data[MAGIC_LO +: 32];
  assign w_rx_bad     = (~(^rx_data)) || (w_rx_op == 2'b00) ||
                        (w_rx_op[1] && (w_rx_magic != MAGIC_NUMBER));
  assign w_id_match   = (w_rx_id == chip_id) || (w_rx_id == GLOBAL_ID);
  assign w_pkt_global = (r_pkt[9:2] == GLOBAL_ID);
  assign w_pkt_cfg    = r_pkt[1];

  // Build the read reply: stored word carrying our ID, read data, reply flag and fresh odd parity
  always_comb begin
    w_reply                     = r_pkt;
    w_reply[DATA_LO +: DATA_W]  = regmap_read_data;
    w_reply[9:2]                = chip_id;
    w_reply[WIDTH-2]            = 1'b1;
    w_reply[WIDTH-1]            = ~(^w_reply[WIDTH-2:0]);
  end

  // Next-state and next-output decode; data outputs hold unless a state reloads them
  always_comb begin
    w_next         = r_state;
    w_pkt          = r_pkt;
    w_cnt          = r_cnt;
    w_rx_ack       = 1'b0;
    w_event_ack    = 1'b0;
    w_fifo_wr_en   = 1'b0;
    w_fifo_wr_data = fifo_wr_data;
    w_tx_load      = 1'b0;
    w_tx_data      = tx_data;
    w_write        = 1'b0;
    w_read         = 1'b0;
    w_addr         = regmap_address;
    w_wdata        = regmap_write_data;
    w_inc_total    = 1'b0;
    w_inc_bad      = 1'b0;
    w_inc_drop     = 1'b0;
    unique case (r_state)
      READY: begin
        w_cnt = 8'd0;
        if (rx_valid) begin
          w_rx_ack = 1'b1;
          w_pkt    = rx_data;
          if (w_rx_bad) begin
            w_next    = BAD_PACKET;
            w_inc_bad = 1'b1;
          end else if ((w_rx_op == 2'b10) && w_id_match) begin
            w_next  = CFG_WRITE;
            w_write = 1'b1;
            w_addr  = w_rx_addr;
            w_wdata = w_rx_field;
          end else if ((w_rx_op == 2'b11) && w_id_match) begin
            w_next = CFG_READ;
            w_read = 1'b1;
            w_addr = w_rx_addr;
          end else begin
            w_next = FWD;
          end
        end else if (event_valid) begin
          w_next         = LOCAL_EVENT;
          w_event_ack    = 1'b1;
          w_fifo_wr_data = pre_event;
          w_inc_total    = 1'b1;
        end
      end
      CFG_WRITE: begin
        w_cnt  = 8'd0;
        w_next = w_pkt_global ? FWD : WAIT_STATE;
      end
      CFG_READ: begin
        if (r_cnt == LAT_LAST) begin
          w_next = CFG_READ_LATCH;
        end else begin
          w_read = 1'b1;
          w_cnt  = r_cnt + 8'd1;
        end
      end
      CFG_READ_LATCH: begin
        w_cnt = 8'd0;
        if (!tx_busy) begin
          w_tx_load = 1'b1;
          w_tx_data = w_reply;
          w_next    = w_pkt_global ? FWD : WAIT_STATE;
        end
      end
      FWD: begin
        w_cnt = 8'd0;
        if (w_pkt_cfg) begin
          if (!tx_busy) begin
            w_tx_load = 1'b1;
            w_tx_data = r_pkt;
            w_next    = WAIT_STATE;
          end
        end else begin
          w_next         = WRITE_FIFO;
          w_fifo_wr_data = r_pkt;
          w_fifo_wr_en   = !fifo_full;
          w_inc_drop     = fifo_full;
        end
      end
      LOCAL_EVENT: begin
        w_next       = WRITE_FIFO;
        w_fifo_wr_en = !fifo_full;
        w_inc_drop   = fifo_full;
      end
      WRITE_FIFO: begin
        w_cnt  = 8'd0;
        w_next = WAIT_STATE;
      end
      BAD_PACKET: begin
        w_next = READY;
      end
      WAIT_STATE: begin
        if (!rx_valid || (r_cnt == TO_LAST)) begin
          w_next = READY;
          w_cnt  = 8'd0;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_next = READY;
      end
    endcase
  end

  // State, captured packet and registered outputs; reset clears everything so no strobe survives an abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= READY;
      r_pkt             <= '0;
      r_cnt             <= 8'd0;
      rx_ack            <= 1'b0;
      event_ack         <= 1'b0;
      fifo_wr_en        <= 1'b0;
      fifo_wr_data      <= '0;
      tx_load           <= 1'b0;
      tx_data           <= '0;
      write_regmap      <= 1'b0;
      read_regmap       <= 1'b0;
      regmap_address    <= '0;
      regmap_write_data <= '0;
      comms_busy        <= 1'b0;
    end else begin
      r_state           <= w_next;
      r_pkt             <= w_pkt;
      r_cnt             <= w_cnt;
      rx_ack            <= w_rx_ack;
      event_ack         <= w_event_ack;
      fifo_wr_en        <= w_fifo_wr_en;
      fifo_wr_data      <= w_fifo_wr_data;
      tx_load           <= w_tx_load;
      tx_data           <= w_tx_data;
      write_regmap      <= w_write;
      read_regmap       <= w_read;
      regmap_address    <= w_addr;
      regmap_write_data <= w_wdata;
      comms_busy        <= (w_next != READY);
    end
  end

  // Saturating statistics counters, bumped on entry to the state they account for
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_packets   <= 16'd0;
      bad_packets     <= 16'd0;
      dropped_packets <= 16'd0;
    end else begin
      if (w_inc_total && (total_packets != 16'hFFFF)) total_packets <= total_packets + 16'd1;
      if (w_inc_bad && (bad_packets != 16'hFFFF)) bad_packets <= bad_packets + 16'd1;
      if (w_inc_drop && (dropped_packets != 16'hFFFF)) dropped_packets <= dropped_packets + 16'd1;
    end
  end

endmodule

// File: tb/tb_comms_ctrl_param.sv
// Directed bench for comms_ctrl_param with hand-built packets and immediate assertions.
module tb_comms_ctrl_param;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [31:0] MAGIC = 32'h89504E47;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        chip_id;
  logic [WIDTH-1:0]  rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic [WIDTH-1:0]  pre_event;
  logic              event_valid;
  logic              event_ack;
  logic              fifo_full;
  logic [WIDTH-1:0]  fifo_wr_data;
  logic              fifo_wr_en;
  logic              tx_busy;
  logic [WIDTH-1:0]  tx_data;
  logic              tx_load;
  logic [ADDR_W-1:0] regmap_address;
  logic [DATA_W-1:0] regmap_write_data;
  logic [DATA_W-1:0] regmap_read_data;
  logic              write_regmap;
  logic              read_regmap;
  logic [15:0]       total_packets;
  logic [15:0]       bad_packets;
  logic [15:0]       dropped_packets;
  logic              comms_busy;

  int checks = 0;
  int errors = 0;

  int nWrite = 0, nReadCyc = 0, nTx = 0, nFifo = 0, nRxAck = 0, nEvAck = 0;
  logic [63:0] txLog   [0:15];
  logic [63:0] fifoLog [0:15];
  logic [7:0]  lastWAddr, lastWData;

  comms_ctrl_param #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(5), .TIMEOUT(15),
    .GLOBAL_ID(8'd255), .MAGIC_NUMBER(MAGIC)
  ) dut (
    .clk(clk), .reset(reset), .chip_id(chip_id),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .pre_event(pre_event), .event_valid(event_valid), .event_ack(event_ack),
    .fifo_full(fifo_full), .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_load(tx_load),
    .regmap_address(regmap_address), .regmap_write_data(regmap_write_data),
    .regmap_read_data(regmap_read_data), .write_regmap(write_regmap),
    .read_regmap(read_regmap), .total_packets(total_packets),
    .bad_packets(bad_packets), .dropped_packets(dropped_packets),
    .comms_busy(comms_busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts strobes and logs payloads once per cycle on the falling edge
  always @(negedge clk) begin
    if (write_regmap) begin
      nWrite++;
      lastWAddr = regmap_address;
      lastWData = regmap_write_data;
    end
    if (read_regmap) nReadCyc++;
    if (tx_load) begin
      txLog[nTx % 16] = tx_data;
      nTx++;
    end
    if (fifo_wr_en) begin
      fifoLog[nFifo % 16] = fifo_wr_data;
      nFifo++;
    end
    if (rx_ack) nRxAck++;
    if (event_ack) nEvAck++;
  end

  function automatic logic [63:0] mkPkt(input logic [1:0] op, input logic [7:0] id,
                                        input logic [7:0] a, input logic [7:0] d,
                                        input logic [31:0] m);
    logic [63:0] w;
    w        = '0;
    w[1:0]   = op;
    w[9:2]   = id;
    w[17:10] = a;
    w[25:18] = d;
    w[57:26] = m;
    w[63]    = ~(^w[62:0]);
    return w;
  endfunction

  function automatic logic [63:0] mkReply(input logic [63:0] w, input logic [7:0] rd,
                                          input logic [7:0] cid);
    logic [63:0] r;
    r        = w;
    r[25:18] = rd;
    r[9:2]   = cid;
    r[62]    = 1'b1;
    r[63]    = ~(^r[62:0]);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] w);
    logic got;
    got      = 1'b0;
    rx_data  = w;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (rx_ack) got = 1'b1;
    end
    rx_valid = 1'b0;
    checkOutput("rx_ack seen", {63'd0, got}, 64'd1);
  endtask

  task automatic sendEvent(input logic [63:0] ev);
    logic got;
    got         = 1'b0;
    pre_event   = ev;
    event_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (event_ack) got = 1'b1;
    end
    event_valid = 1'b0;
    checkOutput("event_ack seen", {63'd0, got}, 64'd1);
  endtask

  task automatic waitIdle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      if (!comms_busy) idle = 1'b1;
      else tick(1);
    end
    checkOutput("idle reached", {63'd0, idle}, 64'd1);
  endtask

  initial begin
    logic [63:0] w, rep;
    int bW, bR, bT, bF, bA, bE;
    logic rxSeen, evSeen, evFirst;

    reset = 1'b1; chip_id = 8'd5; rx_data = '0; rx_valid = 1'b0; pre_event = '0;
    event_valid = 1'b0; fifo_full = 1'b0; tx_busy = 1'b0; regmap_read_data = 8'h3C;
    tick(2);
    $display("[TB] reset state");
    checkOutput("reset comms_busy", {63'd0, comms_busy}, 64'd0);
    checkOutput("reset total", {48'd0, total_packets}, 64'd0);
    checkOutput("reset bad", {48'd0, bad_packets}, 64'd0);
    checkOutput("reset dropped", {48'd0, dropped_packets}, 64'd0);
    checkOutput("reset strobes", {59'd0, tx_load, write_regmap, read_regmap, fifo_wr_en, rx_ack}, 64'd0);
    checkOutput("reset tx_data", tx_data, 64'd0);
    checkOutput("reset regmap_address", {56'd0, regmap_address}, 64'd0);
    reset = 1'b0;
    tick(1);

    // Config write to this chip
    $display("[TB] config write to chip 5");
    bW = nWrite; bT = nTx; bF = nFifo; bA = nRxAck;
    applyStimulus(mkPkt(2'b10, 8'd5, 8'h12, 8'hA5, MAGIC));
    waitIdle();
    checkOutput("cfgwr pulses", 64'(nWrite - bW), 64'd1);
    checkOutput("cfgwr addr", {56'd0, lastWAddr}, 64'h12);
    checkOutput("cfgwr data", {56'd0, lastWData}, 64'hA5);
    checkOutput("cfgwr no tx", 64'(nTx - bT), 64'd0);
    checkOutput("cfgwr no fifo", 64'(nFifo - bF), 64'd0);
    checkOutput("cfgwr rx_ack once", 64'(nRxAck - bA), 64'd1);

    // Broadcast config read: reply then original word
    $display("[TB] broadcast config read");
    bR = nReadCyc; bT = nTx; bW = nWrite;
    w   = mkPkt(2'b11, 8'hFF, 8'h34, 8'h00, MAGIC);
    rep = mkReply(w, 8'h3C, 8'd5);
    applyStimulus(w);
    waitIdle();
    checkOutput("cfgrd read cycles", 64'(nReadCyc - bR), 64'd5);
    checkOutput("cfgrd tx loads", 64'(nTx - bT), 64'd2);
    checkOutput("cfgrd reply word", txLog[bT % 16], rep);
    checkOutput("cfgrd reply parity", {63'd0, ^txLog[bT % 16]}, 64'd1);
    checkOutput("cfgrd forward word", txLog[(bT + 1) % 16], w);
    checkOutput("cfgrd no write", 64'(nWrite - bW), 64'd0);

    // Broadcast config write is also forwarded
    $display("[TB] broadcast config write");
    bW = nWrite; bT = nTx;
    w = mkPkt(2'b10, 8'hFF, 8'h40, 8'h11, MAGIC);
    applyStimulus(w);
    waitIdle();
    checkOutput("bcwr write", 64'(nWrite - bW), 64'd1);
    checkOutput("bcwr tx loads", 64'(nTx - bT), 64'd1);
    checkOutput("bcwr tx word", txLog[bT % 16], w);

    // Foreign config packet waits for the transmitter
    $display("[TB] forward blocked by tx_busy");
    bW = nWrite; bT = nTx;
    tx_busy = 1'b1;
    w = mkPkt(2'b10, 8'd7, 8'h01, 8'h02, MAGIC);
    applyStimulus(w);
    tick(6);
    checkOutput("busy no tx", 64'(nTx - bT), 64'd0);
    checkOutput("busy comms_busy", {63'd0, comms_busy}, 64'd1);
    tx_busy = 1'b0;
    waitIdle();
    checkOutput("busy tx after release", 64'(nTx - bT), 64'd1);
    checkOutput("busy tx word", txLog[bT % 16], w);
    checkOutput("busy no write", 64'(nWrite - bW), 64'd0);

    // Parity error
    $display("[TB] flipped parity");
    bW = nWrite; bT = nTx; bF = nFifo; bA = nRxAck; bR = nReadCyc;
    w = mkPkt(2'b10, 8'd5, 8'h12, 8'hA5, MAGIC);
    w[63] = ~w[63];
    applyStimulus(w);
    waitIdle();
    checkOutput("parity bad count", {48'd0, bad_packets}, 64'd1);
    checkOutput("parity no strobes", 64'((nWrite - bW) + (nTx - bT) + (nFifo - bF) + (nReadCyc - bR)), 64'd0);
    checkOutput("parity rx_ack once", 64'(nRxAck - bA), 64'd1);

    // Invalid op and bad magic
    $display("[TB] invalid op and bad magic");
    applyStimulus(mkPkt(2'b00, 8'd5, 8'h00, 8'h00, MAGIC));
    waitIdle();
    checkOutput("op00 bad count", {48'd0, bad_packets}, 64'd2);
    bW = nWrite;
    applyStimulus(mkPkt(2'b10, 8'd5, 8'h12, 8'hA5, 32'h12345678));
    waitIdle();
    checkOutput("magic bad count", {48'd0, bad_packets}, 64'd3);
    checkOutput("magic no write", 64'(nWrite - bW), 64'd0);

    // Local event into a full FIFO
    $display("[TB] event with fifo full");
    bF = nFifo; bE = nEvAck;
    fifo_full = 1'b1;
    sendEvent(64'h0123_4567_89AB_CDEF);
    waitIdle();
    fifo_full = 1'b0;
    checkOutput("full no write", 64'(nFifo - bF), 64'd0);
    checkOutput("full total", {48'd0, total_packets}, 64'd1);
    checkOutput("full dropped", {48'd0, dropped_packets}, 64'd1);
    checkOutput("full event_ack once", 64'(nEvAck - bE), 64'd1);

    // Simultaneous rx data packet and local event: rx is served first
    $display("[TB] simultaneous rx and event");
    bF = nFifo;
    w = mkPkt(2'b01, 8'd9, 8'h55, 8'h66, 32'h0);
    rx_data = w; rx_valid = 1'b1;
    pre_event = 64'hDEAD_BEEF_0000_1234; event_valid = 1'b1;
    rxSeen = 1'b0; evSeen = 1'b0; evFirst = 1'b0;
    for (int i = 0; i < 60 && !(rxSeen && evSeen); i++) begin
      tick(1);
      if (rx_ack) begin rxSeen = 1'b1; rx_valid = 1'b0; end
      if (event_ack) begin
        if (!rxSeen) evFirst = 1'b1;
        evSeen = 1'b1; event_valid = 1'b0;
      end
    end
    rx_valid = 1'b0; event_valid = 1'b0;
    waitIdle();
    checkOutput("simul rx acked", {63'd0, rxSeen}, 64'd1);
    checkOutput("simul event acked", {63'd0, evSeen}, 64'd1);
    checkOutput("simul event not first", {63'd0, evFirst}, 64'd0);
    checkOutput("simul fifo writes", 64'(nFifo - bF), 64'd2);
    checkOutput("simul first fifo word", fifoLog[bF % 16], w);
    checkOutput("simul second fifo word", fifoLog[(bF + 1) % 16], 64'hDEAD_BEEF_0000_1234);
    checkOutput("simul total", {48'd0, total_packets}, 64'd2);

    // Saturation of total_packets
    $display("[TB] total_packets saturation");
    force dut.total_packets = 16'hFFFE;
    tick(1);
    release dut.total_packets;
    tick(1);
    checkOutput("sat preload", {48'd0, total_packets}, 64'hFFFE);
    sendEvent(64'h1);
    waitIdle();
    checkOutput("sat reach max", {48'd0, total_packets}, 64'hFFFF);
    sendEvent(64'h2);
    waitIdle();
    checkOutput("sat hold max", {48'd0, total_packets}, 64'hFFFF);

    // Reset in the middle of a config read
    $display("[TB] reset during config read");
    bT = nTx; bF = nFifo; bW = nWrite;
    applyStimulus(mkPkt(2'b11, 8'd5, 8'h20, 8'h00, MAGIC));
    tick(2);
    reset = 1'b1;
    #1;
    checkOutput("abort read_regmap", {63'd0, read_regmap}, 64'd0);
    checkOutput("abort comms_busy", {63'd0, comms_busy}, 64'd0);
    checkOutput("abort total", {48'd0, total_packets}, 64'd0);
    checkOutput("abort bad", {48'd0, bad_packets}, 64'd0);
    tick(1);
    reset = 1'b0;
    bR = nReadCyc;
    tick(20);
    checkOutput("abort no tx", 64'(nTx - bT), 64'd0);
    checkOutput("abort no fifo/write", 64'((nFifo - bF) + (nWrite - bW)), 64'd0);
    checkOutput("abort no read", 64'(nReadCyc - bR), 64'd0);
    checkOutput("abort idle", {63'd0, comms_busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
